// File: rtl/servo_pwm_gen_pkg.sv
// Shared constants and types for the servo PWM generator.
// The default timing assumes a 100 MHz clock and a 20 ms frame with a 1-2 ms pulse.
package servo_pkg;

   localparam int DEF_PERIOD_TICKS = 2000000;
   localparam int DEF_MIN_PULSE    = 100000;
   localparam int DEF_MAX_PULSE    = 200000;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } pwm_state_t;

endpackage

// File: rtl/servo_pwm_gen_if.sv
// Command channel from the upstream servo controller.
// A pulse width is transferred on a clock edge where valid and ready are both high.
interface servo_pwm_gen_if #(
   parameter int CNT_W = 21
);

   logic             cmd_valid;
   logic [CNT_W-1:0] cmd_pulse;
   logic             cmd_ready;

   modport master (
      output cmd_valid,
      output cmd_pulse,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_pulse,
      output cmd_ready
   );

endinterface

// File: rtl/servo_pwm_gen_pulse_clamp.sv
// Saturates a requested pulse width into the servo's legal range.
// Also reports whether the request had to be altered.
module pulse_clamp #(
   parameter int W         = 21,
   parameter int MIN_PULSE = 100000,
   parameter int MAX_PULSE = 200000
) (
   input  logic [W-1:0] pulse_in,
   output logic [W-1:0] pulse_out,
   output logic         out_of_range
);

   localparam logic [W-1:0] MIN_V = W'(MIN_PULSE);
   localparam logic [W-1:0] MAX_V = W'(MAX_PULSE);

   // Saturate to [MIN_V, MAX_V] and flag any request outside that window
   always_comb begin
      pulse_out    = pulse_in;
      out_of_range = 1'b0;
      if (pulse_in < MIN_V) begin
         pulse_out    = MIN_V;
         out_of_range = 1'b1;
      end else if (pulse_in > MAX_V) begin
         pulse_out    = MAX_V;
         out_of_range = 1'b1;
      end
   end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: fixed-length frames with a commanded high time.
// New commands are double-buffered so a frame in flight is never altered.
module servo_pwm_gen
   import servo_pkg::*;
#(
   parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
   parameter int MIN_PULSE    = DEF_MIN_PULSE,
   parameter int MAX_PULSE    = DEF_MAX_PULSE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   servo_pwm_gen_if.slave   cmd,
   output logic             pwm_out,
   output logic             period_start,
   output logic             clamp_err
);

   localparam int CNT_W = $clog2(PERIOD_TICKS + 1);
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD_TICKS - 1);
   localparam logic [CNT_W-1:0] CENTRE = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);

   if (!(MIN_PULSE > 0 && MIN_PULSE <= MAX_PULSE && MAX_PULSE < PERIOD_TICKS)) begin : g_bad_params
      $error("servo_pwm_gen: require 0 < MIN_PULSE <= MAX_PULSE < PERIOD_TICKS");
   end

   pwm_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] active;
   logic [CNT_W-1:0] pending;
   logic             pend_full;

   logic [CNT_W-1:0] clamped;
   logic             out_of_range;
   logic             accept;
   logic             wrap;

   pulse_clamp #(
      .W         (CNT_W),
      .MIN_PULSE (MIN_PULSE),
      .MAX_PULSE (MAX_PULSE)
   ) u_clamp (
      .pulse_in     (cmd.cmd_pulse),
      .pulse_out    (clamped),
      .out_of_range (out_of_range)
   );

   // In IDLE a command lands straight in the active register, so we can always take one
   assign cmd.cmd_ready = (state == IDLE) || !pend_full;
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   assign wrap          = (state != IDLE) && (cnt == LAST);

   // Frame sequencing: outputs are registered from the counter, so they trail it by one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt          <= '0;
               pwm_out      <= 1'b0;
               period_start <= 1'b0;
               if (enable) begin
                  state <= RUN;
               end
            end
            RUN, DRAIN: begin
               pwm_out      <= (cnt < active);
               period_start <= (cnt == '0);
               cnt          <= wrap ? '0 : cnt + CNT_W'(1);
               if (enable) begin
                  state <= RUN;
               end else if (wrap) begin
                  state <= IDLE;
               end else begin
                  state <= DRAIN;
               end
            end
            default: begin
               state        <= IDLE;
               cnt          <= '0;
               pwm_out      <= 1'b0;
               period_start <= 1'b0;
            end
         endcase
      end
   end

   // Command storage: active drives the current frame, pending waits for the next wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active    <= CENTRE;
         pending   <= '0;
         pend_full <= 1'b0;
         clamp_err <= 1'b0;
      end else begin
         clamp_err <= accept && out_of_range;
         if (state == IDLE) begin
            if (accept) begin
               active    <= clamped;
               pend_full <= 1'b0;
            end else if (pend_full) begin
               active    <= pending;
               pend_full <= 1'b0;
            end
         end else begin
            if (wrap && pend_full) begin
               active    <= pending;
               pend_full <= 1'b0;
            end
            if (accept) begin
               pending   <= clamped;
               pend_full <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Testbench for servo_pwm_gen with a small frame (20 ticks, pulse 2..10).
// Directed scenarios check frame widths; a randomized run is compared to a frame-level model.
module tb_servo_pwm_gen;

   localparam int PERIOD = 20;
   localparam int MINP   = 2;
   localparam int MAXP   = 10;
   localparam int CENTRE = 6;
   localparam int CNT_W  = $clog2(PERIOD + 1);

   logic clk;
   logic rst_n;
   logic enable;
   logic pwm_out;
   logic period_start;
   logic clamp_err;

   int checks = 0;
   int errors = 0;

   servo_pwm_gen_if #(.CNT_W(CNT_W)) cmd_if ();

   servo_pwm_gen #(
      .PERIOD_TICKS (PERIOD),
      .MIN_PULSE    (MINP),
      .MAX_PULSE    (MAXP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .cmd          (cmd_if.slave),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .clamp_err    (clamp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int sat(int p);
      if (p < MINP) return MINP;
      if (p > MAXP) return MAXP;
      return p;
   endfunction

   // Reference model: a running frame position, the width in force, and at most one queued width
   logic m_on;
   logic m_pend_v;
   int   m_phase;
   int   m_cur;
   int   m_pend;
   logic exp_pwm;
   logic exp_ps;
   logic exp_clamp;
   wire  m_ready = !m_on || !m_pend_v;

   // Advance the model once per clock; frames stop only at their natural end
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_on      <= 1'b0;
         m_pend_v  <= 1'b0;
         m_phase   <= 0;
         m_cur     <= CENTRE;
         m_pend    <= 0;
         exp_pwm   <= 1'b0;
         exp_ps    <= 1'b0;
         exp_clamp <= 1'b0;
      end else begin
         exp_clamp <= cmd_if.cmd_valid && m_ready &&
                      (int'(cmd_if.cmd_pulse) < MINP || int'(cmd_if.cmd_pulse) > MAXP);
         if (!m_on) begin
            exp_pwm <= 1'b0;
            exp_ps  <= 1'b0;
            m_phase <= 0;
            if (enable) m_on <= 1'b1;
            if (cmd_if.cmd_valid) begin
               m_cur    <= sat(int'(cmd_if.cmd_pulse));
               m_pend_v <= 1'b0;
            end else if (m_pend_v) begin
               m_cur    <= m_pend;
               m_pend_v <= 1'b0;
            end
         end else begin
            exp_pwm <= (m_phase < m_cur);
            exp_ps  <= (m_phase == 0);
            m_phase <= (m_phase + 1) % PERIOD;
            if (m_phase == PERIOD - 1) begin
               if (m_pend_v) m_cur <= m_pend;
               if (!enable) m_on <= 1'b0;
            end
            if (cmd_if.cmd_valid && !m_pend_v) begin
               m_pend   <= sat(int'(cmd_if.cmd_pulse));
               m_pend_v <= 1'b1;
            end else if (m_phase == PERIOD - 1) begin
               m_pend_v <= 1'b0;
            end
         end
      end
   end

   task automatic wait_frame_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (period_start === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL frame_start_timeout: got no period_start, expected one within 60 cycles");
      end
   endtask

   task automatic measure_frame(output int high, output bit ps_next);
      bit ok;
      high = 0;
      wait_frame_start(ok);
      for (int i = 0; i < PERIOD; i++) begin
         if (pwm_out === 1'b1) high++;
         @(negedge clk);
      end
      ps_next = (period_start === 1'b1);
   endtask

   task automatic test_reset();
      int activity;
      rst_n = 1'b0;
      enable = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_pulse = '0;
      #2;
      checks++;
      if (pwm_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwm_out: got %b, expected 0", pwm_out); end
      checks++;
      if (period_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_period_start: got %b, expected 0", period_start); end
      checks++;
      if (clamp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_clamp_err: got %b, expected 0", clamp_err); end
      checks++;
      if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b, expected 1", cmd_if.cmd_ready); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      activity = 0;
      repeat (25) begin
         @(negedge clk);
         if (pwm_out !== 1'b0 || period_start !== 1'b0) activity++;
      end
      checks++;
      if (activity != 0) begin errors++; $display("[TB] FAIL idle_without_enable: got %0d active cycles, expected 0", activity); end
   endtask

   task automatic test_default_frame();
      int high;
      bit ps_next;
      enable = 1'b1;
      for (int f = 0; f < 2; f++) begin
         measure_frame(high, ps_next);
         checks++;
         if (high != CENTRE) begin errors++; $display("[TB] FAIL default_width: got %0d, expected %0d", high, CENTRE); end
         checks++;
         if (!ps_next) begin errors++; $display("[TB] FAIL default_period: got no period_start at 20, expected one"); end
      end
   endtask

   task automatic test_mid_frame_cmd();
      bit ok;
      bit ps_next;
      bit r19;
      int high = 0;
      int ready_bad = 0;
      wait_frame_start(ok);
      for (int pos = 0; pos < PERIOD; pos++) begin
         if (pwm_out === 1'b1) high++;
         if (pos == 5) begin
            checks++;
            if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready_before: got %b, expected 1", cmd_if.cmd_ready); end
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_pulse = CNT_W'(4);
         end
         if (pos == 6) cmd_if.cmd_valid = 1'b0;
         if (pos >= 6 && pos <= 18 && cmd_if.cmd_ready !== 1'b0) ready_bad++;
         if (pos == 19) r19 = cmd_if.cmd_ready;
         @(negedge clk);
      end
      checks++;
      if (high != CENTRE) begin errors++; $display("[TB] FAIL mid_current_width: got %0d, expected %0d", high, CENTRE); end
      checks++;
      if (ready_bad != 0) begin errors++; $display("[TB] FAIL mid_ready_blocked: got %0d ready cycles, expected 0", ready_bad); end
      checks++;
      if (r19 !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready_after_wrap: got %b, expected 1", r19); end
      measure_frame(high, ps_next);
      checks++;
      if (high != 4) begin errors++; $display("[TB] FAIL mid_next_width: got %0d, expected 4", high); end
   endtask

   task automatic test_clamp();
      int pulses[3] = '{0, 7, 15};
      int widths[3] = '{2, 7, 10};
      bit flags[3]  = '{1'b1, 1'b0, 1'b1};
      int high;
      bit ok;
      bit ps_next;
      for (int k = 0; k < 3; k++) begin
         wait_frame_start(ok);
         repeat (5) @(negedge clk);
         cmd_if.cmd_valid = 1'b1;
         cmd_if.cmd_pulse = CNT_W'(pulses[k]);
         @(negedge clk);
         cmd_if.cmd_valid = 1'b0;
         checks++;
         if (clamp_err !== flags[k]) begin errors++; $display("[TB] FAIL clamp_flag_%0d: got %b, expected %b", pulses[k], clamp_err, flags[k]); end
         @(negedge clk);
         checks++;
         if (clamp_err !== 1'b0) begin errors++; $display("[TB] FAIL clamp_single_pulse_%0d: got %b, expected 0", pulses[k], clamp_err); end
         measure_frame(high, ps_next);
         checks++;
         if (high != widths[k]) begin errors++; $display("[TB] FAIL clamp_width_%0d: got %0d, expected %0d", pulses[k], high, widths[k]); end
      end
   endtask

   task automatic test_drain();
      bit ok;
      bit ps_next;
      int high = 0;
      int idle_bad = 0;
      wait_frame_start(ok);
      for (int pos = 0; pos < PERIOD; pos++) begin
         if (pwm_out === 1'b1) high++;
         if (pos == 3) enable = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (high != 10) begin errors++; $display("[TB] FAIL drain_full_pulse: got %0d, expected 10", high); end
      repeat (6) begin
         if (pwm_out !== 1'b0 || period_start !== 1'b0) idle_bad++;
         @(negedge clk);
      end
      checks++;
      if (idle_bad != 0) begin errors++; $display("[TB] FAIL drain_then_idle: got %0d active cycles, expected 0", idle_bad); end
      enable = 1'b1;
      measure_frame(high, ps_next);
      checks++;
      if (high != 10) begin errors++; $display("[TB] FAIL drain_restart_width: got %0d, expected 10", high); end
      high = 0;
      for (int pos = 0; pos < PERIOD; pos++) begin
         if (pwm_out === 1'b1) high++;
         if (pos == 3) enable = 1'b0;
         if (pos == 15) enable = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (period_start !== 1'b1) begin errors++; $display("[TB] FAIL drain_reenable_gap: got %b, expected 1", period_start); end
      measure_frame(high, ps_next);
      checks++;
      if (high != 10) begin errors++; $display("[TB] FAIL drain_reenable_width: got %0d, expected 10", high); end
   endtask

   task automatic test_wrap_cmd();
      bit ok;
      bit ps_next;
      int high;
      wait_frame_start(ok);
      repeat (18) @(negedge clk);
      checks++;
      if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ready: got %b, expected 1", cmd_if.cmd_ready); end
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_pulse = CNT_W'(3);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      checks++;
      if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pending_full: got %b, expected 0", cmd_if.cmd_ready); end
      measure_frame(high, ps_next);
      checks++;
      if (high != 10) begin errors++; $display("[TB] FAIL wrap_not_immediate: got %0d, expected 10", high); end
      measure_frame(high, ps_next);
      checks++;
      if (high != 3) begin errors++; $display("[TB] FAIL wrap_applied_later: got %0d, expected 3", high); end
   endtask

   task automatic test_reset_mid_frame();
      bit ps_next;
      int high;
      @(negedge clk);
      checks++;
      if (pwm_out !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_precondition: got %b, expected 1", pwm_out); end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (pwm_out !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_async_drop: got %b, expected 0", pwm_out); end
      checks++;
      if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %b, expected 1", cmd_if.cmd_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      measure_frame(high, ps_next);
      checks++;
      if (high != CENTRE) begin errors++; $display("[TB] FAIL rstmid_centre: got %0d, expected %0d", high, CENTRE); end
   endtask

   task automatic test_random();
      enable = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         checks++;
         if (pwm_out !== exp_pwm) begin errors++; $display("[TB] FAIL rand_pwm_out at %0d: got %b, expected %b", n, pwm_out, exp_pwm); end
         checks++;
         if (period_start !== exp_ps) begin errors++; $display("[TB] FAIL rand_period_start at %0d: got %b, expected %b", n, period_start, exp_ps); end
         checks++;
         if (clamp_err !== exp_clamp) begin errors++; $display("[TB] FAIL rand_clamp_err at %0d: got %b, expected %b", n, clamp_err, exp_clamp); end
         checks++;
         if (cmd_if.cmd_ready !== m_ready) begin errors++; $display("[TB] FAIL rand_cmd_ready at %0d: got %b, expected %b", n, cmd_if.cmd_ready, m_ready); end
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         cmd_if.cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_if.cmd_pulse = ($urandom_range(0, 9) == 0) ? CNT_W'(31) : CNT_W'($urandom_range(0, 15));
         rst_n = ($urandom_range(0, 499) != 0);
      end
      rst_n = 1'b1;
      cmd_if.cmd_valid = 1'b0;
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_default_frame();
      test_mid_frame_cmd();
      test_clamp();
      test_drain();
      test_wrap_cmd();
      test_reset_mid_frame();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/servo_pwm_gen.md
SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 Parameter PERIOD_TICKS, default 2000000, gives the frame length in clk cycles (20 ms at 100 MHz).
REQ-002 Parameter MIN_PULSE, default 100000, gives the minimum high time in cycles (1 ms).
REQ-003 Parameter MAX_PULSE, default 200000, gives the maximum high time in cycles (2 ms).
REQ-004 Localparam CNT_W SHALL equal $clog2(PERIOD_TICKS+1), which is 21 for the defaults.
REQ-005 clk  in  1  is the single clock; all logic SHALL be on its rising edge.
REQ-006 rst_n  in  1  is the asynchronous, active-low reset.
REQ-007 enable  in  1  requests PWM generation.
REQ-008 cmd_valid  in  1  qualifies cmd_pulse from the upstream servo controller.
REQ-009 cmd_pulse  in  CNT_W  is the requested high time in cycles.
REQ-010 cmd_ready  out  1  means a command can be accepted this cycle.
REQ-011 pwm_out  out  1  is the servo drive signal.
REQ-012 period_start  out  1  is a one-cycle pulse on the first cycle of each frame.
REQ-013 clamp_err  out  1  is a one-cycle pulse when an accepted command was clamped.

Function
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-015 An accepted cmd_pulse SHALL be clamped to [MIN_PULSE, MAX_PULSE]; clamp_err SHALL pulse on the edge after acceptance if it was out of range.
REQ-016 Storage: an active register drives the current frame, and a one-entry pending register holds the next command.
REQ-017 cmd_ready SHALL be 1 when state is IDLE or the pending register is empty, else 0.
REQ-018 FSM states: IDLE, RUN, DRAIN.
REQ-019 IDLE: counter held at 0; pwm_out=0; an accepted command writes the active register directly.
REQ-020 IDLE->RUN on an edge sampling enable=1; counter=0 at that edge.
REQ-021 period_start=1 and pwm_out=1 SHALL appear one cycle after the IDLE->RUN edge.
REQ-022 RUN/DRAIN: the counter increments and wraps from PERIOD_TICKS-1 to 0.
REQ-023 Outputs are registered: pwm_out=1 for exactly active-value cycles per frame; period_start=1 on the frame's first output cycle.
REQ-024 At wrap with pending full: pending moves to active and pending is cleared.
REQ-025 At wrap with pending empty: active is kept.
REQ-026 A command accepted on the wrap edge itself SHALL go to pending and take effect at the following wrap.
REQ-027 RUN->DRAIN when enable=0 is sampled mid-frame.
REQ-028 DRAIN completes the current frame unchanged, then goes to IDLE at wrap, so no truncated pulse is produced.
REQ-029 DRAIN->RUN when enable=1 is sampled before wrap, with no gap in the frame.
REQ-030 Active register reset value SHALL be (MIN_PULSE+MAX_PULSE)/2 (centre position).
REQ-031 A parameter check SHALL flag an elaboration error unless 0<MIN_PULSE<=MAX_PULSE<PERIOD_TICKS.

Reset
REQ-032 While rst_n=0, regardless of clk: state=IDLE, counter=0, pending empty, active=centre, and pwm_out, period_start and clamp_err all 0.
REQ-033 Reset mid-frame SHALL drop pwm_out to 0 immediately.
REQ-034 The first frame after reset release requires enable=1 to be sampled.

Structure
REQ-035 Package servo_pkg SHALL hold the default PERIOD/MIN/MAX constants and the state enum type pwm_state_t {IDLE, RUN, DRAIN}.
REQ-036 One sub-module, pulse_clamp (combinational saturate to [MIN, MAX] plus an out-of-range flag), SHALL be instantiated.

Verification (PERIOD_TICKS=20, MIN_PULSE=2, MAX_PULSE=10)
REQ-037 Reset, then enable=1 with no command: pwm_out high 6 cycles and low 14 cycles, repeating; period_start every 20 cycles.
REQ-038 cmd_pulse=4 sent mid-frame: the current frame keeps its width; the next frame is 4 high; cmd_ready is 0 until that wrap.
REQ-039 cmd_pulse=0 gives 2 high; cmd_pulse=15 gives 10 high; each produces one clamp_err pulse.
REQ-040 enable drops at count 3 of a 10-cycle pulse: the full 10-cycle pulse completes, then IDLE with pwm_out=0; re-enable at count 15 of a later DRAIN gives back-to-back frames.
REQ-041 rst_n is asserted while pwm_out=1: pwm_out=0 without waiting for a clk edge, and the active value returns to 6.
REQ-042 A command is accepted on the wrap edge: it is applied one frame later, not immediately.
